// File: rtl/alu_issue_stage_if.sv
// Bus interfaces for the ALU issue stage.
//   issue_in_if  : upstream fetch/regfile side (instruction, operands, flush)
//   issue_out_if : downstream ALU/EX side (operands, op code, control flags)
// In both interfaces the "master" modport is the side that drives the valid.

interface issue_in_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;

  // Upstream: presents instructions and operands, observes in_ready.
  modport master (
    output in_valid, instr, rs1_data, rs2_data, flush,
    input  in_ready
  );

  // Issue stage: consumes instructions, produces in_ready.
  modport slave (
    input  in_valid, instr, rs1_data, rs2_data, flush,
    output in_ready
  );
endinterface

interface issue_out_if #(
  parameter int XLEN = 64,
  parameter int OPW  = 4
);
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [OPW-1:0]  OP;
  logic [4:0]      rd;
  logic            reg_write;
  logic            mem_rd;
  logic            mem_wr;
  logic            illegal;

  // Issue stage: drives the decoded entry toward the ALU.
  modport master (
    output out_valid, A, B, OP, rd, reg_write, mem_rd, mem_wr, illegal,
    input  out_ready
  );

  // ALU/EX consumer: accepts decoded entries.
  modport slave (
    input  out_valid, A, B, OP, rd, reg_write, mem_rd, mem_wr, illegal,
    output out_ready
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Decode/issue stage in front of the 64-bit ALU.
// Decodes OP-IMM, LOAD, STORE and OP instructions, sign-extends immediates,
// selects operand B and generates the ALU op code. Decoded entries are held in
// a main output register backed by one skid register (2-entry FIFO), so
// in_ready is a pure register output and full throughput is kept.
// Optional feature: define ALU_ISSUE_PERF_EN to add issue_cnt/stall_cnt
// performance counters as extra output ports.

module alu_issue_stage #(
  parameter int XLEN = 64,
  parameter int OPW  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  issue_in_if.slave  in_if,
  issue_out_if.master out_if
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0] issue_cnt,
  output logic [31:0] stall_cnt
`endif
);

  // ---------------------------------------------------------------------------
  // Encodings
  // ---------------------------------------------------------------------------
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [OPW-1:0] ALU_AND = OPW'(4'b0000);
  localparam logic [OPW-1:0] ALU_OR  = OPW'(4'b0001);
  localparam logic [OPW-1:0] ALU_ADD = OPW'(4'b0010);
  localparam logic [OPW-1:0] ALU_SUB = OPW'(4'b0110);
  localparam logic [OPW-1:0] ALU_SLT = OPW'(4'b0111);

  // One decoded, issue-ready entry. Everything the ALU/EX side needs is
  // captured here at accept time, so later register-file changes cannot leak
  // into a held entry.
  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [OPW-1:0]  op;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_rd;
    logic            mem_wr;
    logic            illegal;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;

  assign opcode = in_if.instr[6:0];
  assign funct3 = in_if.instr[14:12];
  assign funct7 = in_if.instr[31:25];

  // Bit 11 of the 12-bit immediate (instr[31]) is replicated up to XLEN-1.
  assign imm_i = {{(XLEN-12){in_if.instr[31]}}, in_if.instr[31:20]};
  assign imm_s = {{(XLEN-12){in_if.instr[31]}}, in_if.instr[31:25], in_if.instr[11:7]};

  // rs1 index is resolved by the register file upstream; only its data is used.
  logic unused_rs1_idx;
  assign unused_rs1_idx = &{1'b0, in_if.instr[19:15]};

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  entry_t dec;

  // Combinational decode of the presented instruction into an entry.
  always_comb begin
    // NOTE: every field gets a default first, so no path through the case
    // statements can leave a value unassigned and infer a latch.
    dec           = '0;
    dec.a         = in_if.rs1_data;
    dec.b         = in_if.rs2_data;
    dec.op        = ALU_ADD;
    dec.rd        = in_if.instr[11:7];

    unique case (opcode)
      OPC_OP_IMM: begin
        dec.b         = imm_i;
        dec.reg_write = 1'b1;
        case (funct3)
          F3_ADD:  dec.op = ALU_ADD;
          F3_AND:  dec.op = ALU_AND;
          F3_OR:   dec.op = ALU_OR;
          F3_SLT:  dec.op = ALU_SLT;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.b         = imm_i;
        dec.mem_rd    = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_STORE: begin
        dec.b         = imm_s;
        dec.mem_wr    = 1'b1;
      end
      OPC_OP: begin
        dec.b         = in_if.rs2_data;
        dec.reg_write = 1'b1;
        if (funct7 != F7_BASE && funct7 != F7_ALT) begin
          dec.illegal = 1'b1;
        end
        case (funct3)
          F3_ADD:  dec.op = in_if.instr[30] ? ALU_SUB : ALU_ADD;
          F3_AND:  dec.op = ALU_AND;
          F3_OR:   dec.op = ALU_OR;
          F3_SLT:  dec.op = ALU_SLT;
          default: dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase

    // Illegal entries still flow down the pipe (so the trap is taken in
    // order) but must have no architectural side effects.
    if (dec.illegal) begin
      dec.op        = ALU_ADD;
      dec.reg_write = 1'b0;
      dec.mem_rd    = 1'b0;
      dec.mem_wr    = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Main + skid buffer
  // ---------------------------------------------------------------------------
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;

  logic accept;
  logic drain;

  // The stage can take one more entry as long as the skid slot is free.
  assign in_if.in_ready = !skid_valid_q;

  // flush wins over a simultaneous input: nothing is captured that cycle.
  assign accept = in_if.in_valid && !skid_valid_q && !in_if.flush;
  assign drain  = main_valid_q && out_if.out_ready;

  // Next-state for the two-entry FIFO (main is the head, skid the tail).
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (in_if.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      // Head slot is free (or frees this edge): refill from skid first to
      // keep FIFO order, otherwise load the new entry directly (no bubble).
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Head is stalled: park the new entry in the skid slot.
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the entry payloads are reset too, not just the valid bits,
      // because A/B/OP/rd and the flags must read zero straight out of reset.
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the
      // pre-edge values and the block order does not matter.
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Outputs come straight from the main register.
  assign out_if.out_valid = main_valid_q;
  assign out_if.A         = main_q.a;
  assign out_if.B         = main_q.b;
  assign out_if.OP        = main_q.op;
  assign out_if.rd        = main_q.rd;
  assign out_if.reg_write = main_q.reg_write;
  assign out_if.mem_rd    = main_q.mem_rd;
  assign out_if.mem_wr    = main_q.mem_wr;
  assign out_if.illegal   = main_q.illegal;

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counters wrap naturally at 2^32; flush does not clear them.
  always_comb begin
    issue_cnt_d = issue_cnt_q + 32'(drain);
    stall_cnt_d = stall_cnt_q + 32'(main_valid_q && !out_if.out_ready);
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage: a table of decode vectors with
// hand-computed results, plus sequences for backpressure, flush and reset.

module tb_alu_issue_stage;

  logic clk;
  logic rst_n;

  issue_in_if  #(.XLEN(64))           in_bus ();
  issue_out_if #(.XLEN(64), .OPW(4))  out_bus ();

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] issue_cnt;
  logic [31:0] stall_cnt;
`endif

  alu_issue_stage #(.XLEN(64), .OPW(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_if  (in_bus.slave),
    .out_if (out_bus.master)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .issue_cnt (issue_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference ALU used to confirm the issued A/B/OP triple computes the
  // intended result downstream.
  function automatic logic [63:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      default: return 64'hDEAD_DEAD_DEAD_DEAD;
    endcase
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw;
    logic        mrd;
    logic        mwr;
    logic        ill;
    logic [63:0] o;
  } vec_t;

  vec_t vecs[12];

  // Present one instruction for exactly one accepting edge.
  task automatic push(input logic [31:0] instr, input logic [63:0] rs1, input logic [63:0] rs2);
    @(negedge clk);
    in_bus.in_valid = 1'b1;
    in_bus.instr    = instr;
    in_bus.rs1_data = rs1;
    in_bus.rs2_data = rs2;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " out_valid"}, 64'(out_bus.out_valid), 64'd0);
    check({tag, " in_ready"},  64'(in_bus.in_ready),   64'd1);
    check({tag, " A"},         out_bus.A,              64'd0);
    check({tag, " B"},         out_bus.B,              64'd0);
    check({tag, " OP"},        64'(out_bus.OP),        64'd0);
    check({tag, " rd"},        64'(out_bus.rd),        64'd0);
    check({tag, " flags"},     64'({out_bus.reg_write, out_bus.mem_rd,
                                    out_bus.mem_wr, out_bus.illegal}), 64'd0);
  endtask

  initial begin
    //                 instr          rs1                    rs2     B                      OP       rd  rw mrd mwr ill O
    vecs[0]  = '{32'h0030_8293, 64'd2,                 64'd0,  64'd3,                 4'b0010, 5'd5,  1, 0, 0, 0, 64'd5};
    vecs[1]  = '{32'hFFF0_8293, 64'd2,                 64'd0,  64'hFFFF_FFFF_FFFF_FFFF, 4'b0010, 5'd5, 1, 0, 0, 0, 64'd1};
    vecs[2]  = '{32'h4020_81B3, 64'd7,                 64'd7,  64'd7,                 4'b0110, 5'd3,  1, 0, 0, 0, 64'd0};
    vecs[3]  = '{32'h0FF0_F093, 64'h1234,              64'd0,  64'hFF,                4'b0000, 5'd1,  1, 0, 0, 0, 64'h34};
    vecs[4]  = '{32'h8000_E113, 64'd5,                 64'd0,  64'hFFFF_FFFF_FFFF_F800, 4'b0001, 5'd2, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_F805};
    vecs[5]  = '{32'h0020_A233, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1,               4'b0111, 5'd4,  1, 0, 0, 0, 64'd1};
    vecs[6]  = '{32'h0080_A303, 64'h1000,              64'd0,  64'd8,                 4'b0010, 5'd6,  1, 1, 0, 0, 64'h1008};
    vecs[7]  = '{32'hFE20_AE23, 64'h1000,              64'hAA, 64'hFFFF_FFFF_FFFF_FFFC, 4'b0010, 5'd28, 0, 0, 1, 0, 64'hFFC};
    vecs[8]  = '{32'h0220_8233, 64'd3,                 64'd4,  64'd0,                 4'b0010, 5'd4,  0, 0, 0, 1, 64'd0};
    vecs[9]  = '{32'h0010_9093, 64'd3,                 64'd4,  64'd0,                 4'b0010, 5'd1,  0, 0, 0, 1, 64'd0};
    vecs[10] = '{32'h0000_107F, 64'd3,                 64'd4,  64'd0,                 4'b0010, 5'd0,  0, 0, 0, 1, 64'd0};
    vecs[11] = '{32'h0020_81B3, 64'd10,                64'd20, 64'd20,                4'b0010, 5'd3,  1, 0, 0, 0, 64'd30};

    in_bus.in_valid    = 1'b0;
    in_bus.instr       = '0;
    in_bus.rs1_data    = '0;
    in_bus.rs2_data    = '0;
    in_bus.flush       = 1'b0;
    out_bus.out_ready  = 1'b0;
    rst_n              = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ---- Backpressure: three ADDIs (imm 1,2,3) into a stalled stage --------
    push(32'h0010_8293, 64'd0, 64'd0);
    @(posedge clk); #1;
    check("bp1 out_valid", 64'(out_bus.out_valid), 64'd1);
    check("bp1 in_ready",  64'(in_bus.in_ready),   64'd1);
    check("bp1 B",         out_bus.B,              64'd1);
    push(32'h0020_8293, 64'd0, 64'd0);
    @(posedge clk); #1;
    check("bp2 in_ready",  64'(in_bus.in_ready),   64'd0);
    check("bp2 B stable",  out_bus.B,              64'd1);
    push(32'h0030_8293, 64'd0, 64'd0);
    @(posedge clk); #1;
    check("bp3 in_ready",  64'(in_bus.in_ready),   64'd0);
    check("bp3 B stable",  out_bus.B,              64'd1);
    @(negedge clk);
    out_bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp drain1 B",        out_bus.B,              64'd2);
    check("bp drain1 valid",    64'(out_bus.out_valid), 64'd1);
    check("bp drain1 in_ready", 64'(in_bus.in_ready),   64'd1);
    @(posedge clk); #1;
    in_bus.in_valid = 1'b0;
    check("bp drain2 B",     out_bus.B,              64'd3);
    check("bp drain2 valid", 64'(out_bus.out_valid), 64'd1);
    @(posedge clk); #1;
    check("bp empty valid",  64'(out_bus.out_valid), 64'd0);
    check("bp empty ready",  64'(in_bus.in_ready),   64'd1);
`ifdef ALU_ISSUE_PERF_EN
    check("perf issue_cnt", 64'(issue_cnt), 64'd3);
    check("perf stall_cnt", 64'(stall_cnt), 64'd2);
`endif

    // ---- Decode table, streamed back-to-back with out_ready=1 -------------
    for (int i = 0; i < 12; i++) begin
      push(vecs[i].instr, vecs[i].rs1, vecs[i].rs2);
      @(posedge clk); #1;
      in_bus.in_valid = 1'b0;
      // Disturb the register-file data: the held entry must not follow it.
      in_bus.rs1_data = ~vecs[i].rs1;
      in_bus.rs2_data = ~vecs[i].rs2;
      #1;
      check($sformatf("v%0d out_valid", i), 64'(out_bus.out_valid), 64'd1);
      check($sformatf("v%0d A", i),         out_bus.A,              vecs[i].rs1);
      check($sformatf("v%0d OP", i),        64'(out_bus.OP),        64'(vecs[i].op));
      check($sformatf("v%0d rd", i),        64'(out_bus.rd),        64'(vecs[i].rd));
      check($sformatf("v%0d flags", i),
            64'({out_bus.reg_write, out_bus.mem_rd, out_bus.mem_wr, out_bus.illegal}),
            64'({vecs[i].rw, vecs[i].mrd, vecs[i].mwr, vecs[i].ill}));
      if (!vecs[i].ill) begin
        check($sformatf("v%0d B", i),     out_bus.B, vecs[i].b);
        check($sformatf("v%0d ALU O", i), alu_model(out_bus.A, out_bus.B, out_bus.OP), vecs[i].o);
      end
    end
    @(posedge clk); #1;
    check("table drained valid", 64'(out_bus.out_valid), 64'd0);

    // ---- Flush with both entries full and input presented -----------------
    out_bus.out_ready = 1'b0;
    push(32'h0010_8293, 64'd0, 64'd0);
    @(posedge clk);
    push(32'h0020_8293, 64'd0, 64'd0);
    @(posedge clk);
    push(32'h0070_8293, 64'd0, 64'd0);
    in_bus.flush = 1'b1;
    @(posedge clk); #1;
    check("flush full valid",    64'(out_bus.out_valid), 64'd0);
    check("flush full in_ready", 64'(in_bus.in_ready),   64'd1);
    @(negedge clk);
    in_bus.flush    = 1'b0;
    in_bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("flush full no capture", 64'(out_bus.out_valid), 64'd0);

    // ---- Flush with one entry held and input presented (in_ready=1) -------
    push(32'h0010_8293, 64'd0, 64'd0);
    @(posedge clk);
    push(32'h0050_8293, 64'd0, 64'd0);
    in_bus.flush = 1'b1;
    @(posedge clk); #1;
    check("flush one valid",    64'(out_bus.out_valid), 64'd0);
    check("flush one in_ready", 64'(in_bus.in_ready),   64'd1);
    @(negedge clk);
    in_bus.flush    = 1'b0;
    in_bus.in_valid = 1'b0;
    out_bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("flush one no capture", 64'(out_bus.out_valid), 64'd0);

    // ---- Asynchronous reset in the middle of a stall ----------------------
    out_bus.out_ready = 1'b0;
    push(32'h0040_8293, 64'd9, 64'd0);
    @(posedge clk);
    push(32'h0060_8293, 64'd9, 64'd0);
    @(posedge clk);
    @(negedge clk);
    in_bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_values("async rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post rst valid", 64'(out_bus.out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
